free_list_mp: RTL and testbench

- Parametrised multi-port physical-register free list for the scalar rename stage.
- Supplies up to POP_PORTS free physical tags per cycle to rename.
- Accepts up to PUSH_PORTS released tags per cycle from commit.
- Holds NUM_CKPT head-pointer checkpoints, so a branch mispredict restores every tag allocated after the branch in one cycle.

---
 rtl/free_list_pkg.sv | 52 +++++
 rtl/fl_push_compact.sv | 68 ++++++
 rtl/free_list_mp.sv | 196 +++++++++++++++++++
 tb/tb_free_list_mp.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/free_list_pkg.sv
// ---------------------------------------------------------------------------
// free_list_pkg
// Shared types and helpers for the multi-port physical-register free list.
//
// Contents:
//   *_DEF         default sizing for the rename free list
//   tag_t         physical register tag (clog2(NUM_PREGS) bits)
//   ptr_t         ring pointer with extra wrap bit (clog2(DEPTH)+1 bits)
//   ckpt_id_t     checkpoint slot index
//   port_cnt_t    count of ports (0..MAX_PORTS)
//   port_ofs_t    per-port offsets produced by popcount_prefix()
//   popcount_prefix() / popcount_all()
// ---------------------------------------------------------------------------
package free_list_pkg;

    localparam int NUM_PREGS_DEF = 64;
    localparam int NUM_AREGS_DEF = 32;
    localparam int DEPTH_DEF     = 64;
    localparam int NUM_CKPT_DEF  = 4;
    localparam int MAX_PORTS     = 4;

    localparam int TW_DEF = $clog2(NUM_PREGS_DEF);
    localparam int PW_DEF = $clog2(DEPTH_DEF) + 1;
    localparam int CW_DEF = $clog2(NUM_CKPT_DEF);

    typedef logic [TW_DEF-1:0] tag_t;
    typedef logic [PW_DEF-1:0] ptr_t;
    typedef logic [CW_DEF-1:0] ckpt_id_t;
    typedef logic [2:0]        port_cnt_t;
    typedef port_cnt_t [MAX_PORTS-1:0] port_ofs_t;

    // Offset of each port = number of asserted lower-indexed request bits.
    // Used to compact sparse requests onto consecutive ring slots.
    function automatic port_ofs_t popcount_prefix(input logic [MAX_PORTS-1:0] req);
        port_ofs_t ofs;
        port_cnt_t acc;
        acc = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            ofs[i] = acc;
            acc    = acc + port_cnt_t'(req[i]);
        end
        return ofs;
    endfunction

    // Total number of asserted request bits.
    function automatic port_cnt_t popcount_all(input logic [MAX_PORTS-1:0] req);
        port_ofs_t ofs;
        ofs = popcount_prefix(req);
        return ofs[MAX_PORTS-1] + port_cnt_t'(req[MAX_PORTS-1]);
    endfunction

endpackage

// File: rtl/fl_push_compact.sv
// ---------------------------------------------------------------------------
// fl_push_compact
// Compacts the asserted release ports, in ascending port order, onto
// consecutive write slots starting at the ring tail. Slots beyond the
// remaining ring space are suppressed, so the highest-indexed ports are the
// ones dropped on overflow.
//
// Ports:
//   push_req   in   PUSH_PORTS      release strobes (any subset)
//   push_tag   in   PUSH_PORTS*TW   released tags
//   accept_max in   3               slots available this cycle (<= PUSH_PORTS)
//   slot_we    out  PUSH_PORTS      write enable for slot tail+k
//   slot_data  out  PUSH_PORTS*TW   data for slot tail+k
//   push_cnt   out  3               number of tags actually accepted
//   push_drop  out  1               at least one release was dropped
// ---------------------------------------------------------------------------
module fl_push_compact
    import free_list_pkg::*;
#(
    parameter int PUSH_PORTS = 2,
    parameter int TW         = 6
) (
    input  logic [PUSH_PORTS-1:0]    push_req,
    input  logic [PUSH_PORTS*TW-1:0] push_tag,
    input  logic [2:0]               accept_max,
    output logic [PUSH_PORTS-1:0]    slot_we,
    output logic [PUSH_PORTS*TW-1:0] slot_data,
    output logic [2:0]               push_cnt,
    output logic                     push_drop
);

    logic [MAX_PORTS-1:0] req_pad;
    port_ofs_t            ofs;
    port_cnt_t            req_total;

    // Pad the request vector to the package's fixed port width so the
    // shared prefix-count helper can be reused for any port count.
    always_comb begin
        req_pad                 = '0;
        req_pad[PUSH_PORTS-1:0] = push_req;
    end

    assign ofs       = popcount_prefix(req_pad);
    assign req_total = popcount_all(req_pad);

    // Slot k takes the tag of the unique asserted port whose prefix offset
    // equals k, provided that slot still fits in the ring.
    always_comb begin
        slot_we   = '0;
        slot_data = '0;
        for (int k = 0; k < PUSH_PORTS; k++) begin
            for (int i = 0; i < PUSH_PORTS; i++) begin
                if (push_req[i] && (ofs[i] == port_cnt_t'(k)) && (ofs[i] < accept_max)) begin
                    slot_we[k]             = 1'b1;
                    slot_data[k*TW +: TW]  = push_tag[i*TW +: TW];
                end
            end
        end
    end

    // Accepted count saturates at the available space; anything above it
    // is an overflow.
    always_comb begin
        push_drop = (req_total > accept_max);
        push_cnt  = push_drop ? accept_max : req_total;
    end

endmodule

// File: rtl/free_list_mp.sv
// ---------------------------------------------------------------------------
// free_list_mp
// Multi-port physical-register free list for the rename stage. A circular
// RAM holds free tags between head (allocation) and tail (release). Pointers
// carry an extra wrap bit so full and empty are distinguishable. Head
// checkpoints allow a mispredict to return every post-branch allocation in
// a single cycle.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pop_req         allocation requests (prefix-contiguous)
//   pop_valid       bit i = at least i+1 entries free
//   pop_tag         tag presented on each pop port (zero latency)
//   push_req        release strobes (any subset)
//   push_tag        released tags
//   ckpt_take/id    save post-pop head into a checkpoint slot
//   restore/id      rewind head from a checkpoint slot
//   free_cnt        number of free entries (tail - head)
//   ready           room for a full set of releases next cycle
//   overflow_err    sticky, a release was dropped for lack of space
//   pop_err         sticky, invalid or non-prefix pop request
// ---------------------------------------------------------------------------
module free_list_mp
    import free_list_pkg::*;
#(
    parameter int NUM_PREGS  = NUM_PREGS_DEF,
    parameter int NUM_AREGS  = NUM_AREGS_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int POP_PORTS  = 2,
    parameter int PUSH_PORTS = 2,
    parameter int NUM_CKPT   = NUM_CKPT_DEF,
    localparam int TW = $clog2(NUM_PREGS),
    localparam int AW = $clog2(DEPTH),
    localparam int PW = AW + 1,
    localparam int CW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [POP_PORTS-1:0]     pop_req,
    output logic [POP_PORTS-1:0]     pop_valid,
    output logic [POP_PORTS*TW-1:0]  pop_tag,
    input  logic [PUSH_PORTS-1:0]    push_req,
    input  logic [PUSH_PORTS*TW-1:0] push_tag,
    input  logic                     ckpt_take,
    input  logic [CW-1:0]            ckpt_id,
    input  logic                     restore,
    input  logic [CW-1:0]            restore_id,
    output logic [PW-1:0]            free_cnt,
    output logic                     ready,
    output logic                     overflow_err,
    output logic                     pop_err
);

    localparam int INIT_FREE = NUM_PREGS - NUM_AREGS;

    logic [TW-1:0]           mem  [DEPTH];
    logic [PW-1:0]           ckpt [NUM_CKPT];
    logic [PW-1:0]           head;
    logic [PW-1:0]           tail;
    logic [PW-1:0]           head_post_pop;
    logic [PW-1:0]           space;
    logic [MAX_PORTS-1:0]    pop_fire;
    port_cnt_t               pop_cnt;
    logic                    bad_pop;
    logic [2:0]              accept_max;
    logic [PUSH_PORTS-1:0]   slot_we;
    logic [PUSH_PORTS*TW-1:0] slot_data;
    logic [2:0]              push_cnt;
    logic                    push_drop;

    // Occupancy comes straight from the pointer difference; the wrap bit
    // makes tail - head == DEPTH mean full rather than empty.
    assign free_cnt = tail - head;
    assign space    = PW'(DEPTH) - free_cnt;
    assign ready    = (space >= PW'(PUSH_PORTS));

    // Pop ports read the ring combinationally so rename sees tags in the
    // same cycle it asks. Validity depends only on current occupancy, so a
    // same-cycle release never makes an empty list look non-empty.
    always_comb begin
        pop_valid = '0;
        pop_tag   = '0;
        for (int i = 0; i < POP_PORTS; i++) begin
            pop_valid[i]        = (free_cnt > PW'(i));
            pop_tag[i*TW +: TW] = mem[head[AW-1:0] + AW'(i)];
        end
    end

    // Only pops that are both requested and valid consume entries. Any
    // request on an invalid port, or a hole in the request vector, is
    // flagged as a protocol error.
    always_comb begin
        pop_fire = '0;
        bad_pop  = 1'b0;
        for (int i = 0; i < POP_PORTS; i++) begin
            pop_fire[i] = pop_req[i] & pop_valid[i];
            if (pop_req[i] && !pop_valid[i]) begin
                bad_pop = 1'b1;
            end
        end
        for (int i = 1; i < POP_PORTS; i++) begin
            if (pop_req[i] && !pop_req[i-1]) begin
                bad_pop = 1'b1;
            end
        end
    end

    assign pop_cnt       = popcount_all(pop_fire);
    assign head_post_pop = head + PW'(pop_cnt);

    // Space left in the ring, clamped to the number of release ports, tells
    // the compactor how many released tags can be written this cycle.
    always_comb begin
        if (space >= PW'(PUSH_PORTS)) begin
            accept_max = 3'(PUSH_PORTS);
        end else begin
            accept_max = space[2:0];
        end
    end

    fl_push_compact #(
        .PUSH_PORTS (PUSH_PORTS),
        .TW         (TW)
    ) u_push_compact (
        .push_req   (push_req),
        .push_tag   (push_tag),
        .accept_max (accept_max),
        .slot_we    (slot_we),
        .slot_data  (slot_data),
        .push_cnt   (push_cnt),
        .push_drop  (push_drop)
    );

    // Ring storage: reset loads the non-architectural tags in ascending
    // order; afterwards each accepted release lands at tail+k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i < INIT_FREE) ? TW'(NUM_AREGS + i) : '0;
            end
        end else begin
            for (int k = 0; k < PUSH_PORTS; k++) begin
                if (slot_we[k]) begin
                    mem[tail[AW-1:0] + AW'(k)] <= slot_data[k*TW +: TW];
                end
            end
        end
    end

    // Pointer update. A restore overrides this cycle's pops entirely, while
    // releases still advance tail because commit is independent of the
    // mispredict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= PW'(INIT_FREE);
        end else begin
            tail <= tail + PW'(push_cnt);
            if (restore) begin
                head <= ckpt[restore_id];
            end else begin
                head <= head_post_pop;
            end
        end
    end

    // Checkpoints capture the head after this cycle's pops so the branch's
    // own allocations survive a later restore. A take that collides with a
    // restore is discarded since the branch it belongs to is being squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                ckpt[i] <= '0;
            end
        end else if (ckpt_take && !restore) begin
            ckpt[ckpt_id] <= head_post_pop;
        end
    end

    // Sticky error flags; pop requests during a restore are expected
    // squash noise and do not count as errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
            pop_err      <= 1'b0;
        end else begin
            if (push_drop) begin
                overflow_err <= 1'b1;
            end
            if (bad_pop && !restore) begin
                pop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_free_list_mp.sv
// ---------------------------------------------------------------------------
// tb_free_list_mp
// Directed and randomised checks of free_list_mp against a reference model
// that tracks an unbounded log of written tags with absolute head/tail
// counts.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_free_list_mp;
    import free_list_pkg::*;

    localparam int DEPTH = 64;
    localparam int NAR   = 32;
    localparam int NPR   = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pop_req;
    logic [1:0] pop_valid;
    logic [11:0] pop_tag;
    logic [1:0] push_req;
    logic [11:0] push_tag;
    logic       ckpt_take;
    ckpt_id_t   ckpt_id;
    logic       restore;
    ckpt_id_t   restore_id;
    ptr_t       free_cnt;
    logic       ready;
    logic       overflow_err;
    logic       pop_err;

    int total = 0;
    int bad   = 0;

    int m_log [int];
    int m_head;
    int m_tail;
    int m_ckpt [4];
    int m_ovf;
    int m_perr;
    int alloc_q [$];

    free_list_mp dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pop_req      (pop_req),
        .pop_valid    (pop_valid),
        .pop_tag      (pop_tag),
        .push_req     (push_req),
        .push_tag     (push_tag),
        .ckpt_take    (ckpt_take),
        .ckpt_id      (ckpt_id),
        .restore      (restore),
        .restore_id   (restore_id),
        .free_cnt     (free_cnt),
        .ready        (ready),
        .overflow_err (overflow_err),
        .pop_err      (pop_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic driveIdle();
        pop_req    = '0;
        push_req   = '0;
        push_tag   = '0;
        ckpt_take  = 1'b0;
        ckpt_id    = '0;
        restore    = 1'b0;
        restore_id = '0;
    endtask

    task automatic modelReset();
        m_log.delete();
        for (int i = 0; i < NPR - NAR; i++) begin
            m_log[i] = NAR + i;
        end
        m_head = 0;
        m_tail = NPR - NAR;
        for (int i = 0; i < 4; i++) begin
            m_ckpt[i] = 0;
        end
        m_ovf  = 0;
        m_perr = 0;
    endtask

    task automatic compareModel();
        int mfree;
        int ev;
        mfree = m_tail - m_head;
        ev = ((mfree > 1) ? 2 : 0) | ((mfree > 0) ? 1 : 0);
        checkOutput("free_cnt", int'(free_cnt), mfree);
        checkOutput("pop_valid", int'(pop_valid), ev);
        if (mfree > 0) checkOutput("pop_tag0", int'(pop_tag[5:0]), m_log[m_head]);
        if (mfree > 1) checkOutput("pop_tag1", int'(pop_tag[11:6]), m_log[m_head + 1]);
        checkOutput("ready", int'(ready), (mfree + 2 <= DEPTH) ? 1 : 0);
        checkOutput("overflow_err", int'(overflow_err), m_ovf);
        checkOutput("pop_err", int'(pop_err), m_perr);
    endtask

    // One clock of stimulus: drive, predict, clock, then compare.
    task automatic applyStimulus(input logic [1:0] pr, input logic [1:0] ur,
                                 input int t0, input int t1,
                                 input bit take, input int tid,
                                 input bit rs, input int rid);
        int mfree;
        int pops;
        int space;
        int nt;
        pop_req    = pr;
        push_req   = ur;
        push_tag   = {6'(t1), 6'(t0)};
        ckpt_take  = take;
        ckpt_id    = 2'(tid);
        restore    = rs;
        restore_id = 2'(rid);

        mfree = m_tail - m_head;
        pops  = 0;
        for (int i = 0; i < 2; i++) begin
            if (pr[i]) begin
                if (mfree > i) pops++;
                else if (!rs) m_perr = 1;
            end
        end
        if (pr == 2'b10 && !rs) m_perr = 1;
        space = DEPTH - mfree;
        nt = m_tail;
        for (int i = 0; i < 2; i++) begin
            if (ur[i]) begin
                if (nt - m_tail < space) begin
                    m_log[nt] = (i == 0) ? t0 : t1;
                    nt++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
        if (take && !rs) m_ckpt[tid] = m_head + pops;
        m_head = rs ? m_ckpt[rid] : m_head + pops;
        m_tail = nt;

        @(posedge clk);
        #1;
        driveIdle();
        compareModel();
    endtask

    task automatic doReset();
        driveIdle();
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_free_cnt", int'(free_cnt), NPR - NAR);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int np;
        int nu;
        int mfree;
        int rt0;
        int rt1;
        int tg;
        int found;
        logic [1:0] pr;
        logic [1:0] ur;

        rst_n = 1'b1;
        driveIdle();
        doReset();

        $display("[TB] reset defaults");
        checkOutput("rst_free_cnt", int'(free_cnt), 32);
        checkOutput("rst_pop_tag0", int'(pop_tag[5:0]), 32);
        checkOutput("rst_pop_tag1", int'(pop_tag[11:6]), 33);
        checkOutput("rst_pop_valid", int'(pop_valid), 3);
        checkOutput("rst_ready", int'(ready), 1);
        checkOutput("rst_overflow_err", int'(overflow_err), 0);
        checkOutput("rst_pop_err", int'(pop_err), 0);

        $display("[TB] drain all tags");
        for (int c = 0; c < 16; c++) begin
            checkOutput("drain_tag0", int'(pop_tag[5:0]), 32 + 2 * c);
            checkOutput("drain_tag1", int'(pop_tag[11:6]), 33 + 2 * c);
            applyStimulus(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        end
        checkOutput("empty_free_cnt", int'(free_cnt), 0);
        checkOutput("empty_pop_valid", int'(pop_valid), 0);
        applyStimulus(2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("extra_pop_err", int'(pop_err), 1);
        checkOutput("extra_pop_free_cnt", int'(free_cnt), 0);

        $display("[TB] push from empty on port 1");
        applyStimulus(2'b00, 2'b10, 0, 7, 0, 0, 0, 0);
        checkOutput("push1_tag0", int'(pop_tag[5:0]), 7);
        checkOutput("push1_pop_valid", int'(pop_valid), 1);
        checkOutput("push1_free_cnt", int'(free_cnt), 1);

        $display("[TB] checkpoint and restore");
        doReset();
        applyStimulus(2'b11, 2'b00, 0, 0, 1, 1, 0, 0);
        applyStimulus(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        applyStimulus(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        applyStimulus(2'b11, 2'b01, 5, 0, 0, 0, 1, 1);
        checkOutput("restore_free_cnt", int'(free_cnt), 31);
        checkOutput("restore_tag0", int'(pop_tag[5:0]), 34);
        checkOutput("restore_pop_err", int'(pop_err), 0);
        applyStimulus(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        applyStimulus(2'b00, 2'b00, 0, 0, 1, 1, 1, 2);
        checkOutput("take_with_restore_free_cnt", int'(free_cnt), 33);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
        checkOutput("take_ignored_free_cnt", int'(free_cnt), 31);

        $display("[TB] random push/pop with wrap");
        doReset();
        alloc_q.delete();
        for (int c = 0; c < 300; c++) begin
            mfree = m_tail - m_head;
            np = $urandom_range(0, 2);
            if (np > mfree) np = mfree;
            pr = (np == 0) ? 2'b00 : (np == 1) ? 2'b01 : 2'b11;
            nu = $urandom_range(0, 2);
            if (nu > alloc_q.size()) nu = alloc_q.size();
            rt0 = 0;
            rt1 = 0;
            ur  = 2'b00;
            if (nu == 2) begin
                ur  = 2'b11;
                rt0 = alloc_q.pop_front();
                rt1 = alloc_q.pop_front();
            end else if (nu == 1) begin
                if ($urandom_range(0, 1) == 1) begin
                    ur  = 2'b10;
                    rt1 = alloc_q.pop_front();
                end else begin
                    ur  = 2'b01;
                    rt0 = alloc_q.pop_front();
                end
            end
            for (int i = 0; i < np; i++) begin
                tg = (i == 0) ? int'(pop_tag[5:0]) : int'(pop_tag[11:6]);
                found = 0;
                foreach (alloc_q[j]) begin
                    if (alloc_q[j] == tg) found = 1;
                end
                checkOutput("no_dup", found, 0);
                alloc_q.push_back(tg);
            end
            applyStimulus(pr, ur, rt0, rt1, 0, 0, 0, 0);
        end

        $display("[TB] fill to capacity and overflow");
        doReset();
        for (int c = 0; c < 31; c++) begin
            applyStimulus(2'b00, 2'b01, c, 0, 0, 0, 0, 0);
        end
        checkOutput("fill_free_cnt", int'(free_cnt), 63);
        checkOutput("fill_ready", int'(ready), 0);
        applyStimulus(2'b00, 2'b11, 11, 12, 0, 0, 0, 0);
        checkOutput("ovf_free_cnt", int'(free_cnt), 64);
        checkOutput("ovf_flag", int'(overflow_err), 1);
        checkOutput("ovf_ready", int'(ready), 0);
        for (int c = 0; c < 32; c++) begin
            applyStimulus(2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        end
        checkOutput("ovf_drained", int'(free_cnt), 0);

        $display("[TB] non-prefix pop request");
        doReset();
        applyStimulus(2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("nonprefix_pop_err", int'(pop_err), 1);
        checkOutput("nonprefix_free_cnt", int'(free_cnt), 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
